// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Purpose  : Shared encodings for the UART TX line arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_TAG  = 2'd2
    } state_t;

    localparam logic [7:0] LF   = 8'h0A;
    localparam logic       SRC0 = 1'b0;
    localparam logic       SRC1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Line-granular two-source arbiter in front of the UART TX core.
//            UART_ARB_TAG_EN: prefix each change of owner with a tag byte.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 4800,
    parameter int MAX_BURST    = 64
`ifdef UART_ARB_TAG_EN
    ,
    parameter logic [7:0] TAG0 = 8'h43,
    parameter logic [7:0] TAG1 = 8'h55
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    output logic       s1_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [1:0] grant,
    output logic       busy
);

    localparam logic [12:0] IDLE_LIM  = 13'(IDLE_TIMEOUT);
    localparam logic [6:0]  BURST_LIM = 7'(MAX_BURST);

    state_t      state, state_nx;
    logic        sel, sel_nx;
    logic        rr_ptr, rr_ptr_nx;
    logic [6:0]  burst_cnt, burst_cnt_nx;
    logic [12:0] idle_cnt, idle_cnt_nx;
`ifdef UART_ARB_TAG_EN
    logic        last_vld, last_vld_nx;
    logic        last_src, last_src_nx;
`endif

    logic        pick;
    logic        g_valid;
    logic [7:0]  g_data;
    logic        xfer;
    logic        rel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sel       <= SRC0;
            rr_ptr    <= SRC0;
            burst_cnt <= '0;
            idle_cnt  <= '0;
`ifdef UART_ARB_TAG_EN
            last_vld  <= 1'b0;
            last_src  <= SRC0;
`endif
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            rr_ptr    <= rr_ptr_nx;
            burst_cnt <= burst_cnt_nx;
            idle_cnt  <= idle_cnt_nx;
`ifdef UART_ARB_TAG_EN
            last_vld  <= last_vld_nx;
            last_src  <= last_src_nx;
`endif
        end
    end

    always_comb begin
        g_data  = (sel == SRC1) ? s1_data  : s0_data;
        g_valid = (sel == SRC1) ? s1_valid : s0_valid;
        pick    = (s0_valid && s1_valid) ? rr_ptr : (s1_valid ? SRC1 : SRC0);
        xfer    = 1'b0;
        rel     = 1'b0;

        state_nx     = state;
        sel_nx       = sel;
        rr_ptr_nx    = rr_ptr;
        burst_cnt_nx = burst_cnt;
        idle_cnt_nx  = idle_cnt;
`ifdef UART_ARB_TAG_EN
        last_vld_nx  = last_vld;
        last_src_nx  = last_src;
`endif

        m_data   = 8'h00;
        m_valid  = 1'b0;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        busy     = (state != ST_IDLE);
        grant    = 2'b00;
        if (state != ST_IDLE)
            grant = (sel == SRC1) ? 2'b10 : 2'b01;

        case (state)
            ST_IDLE: begin
                // Counters start fresh for every grant
                burst_cnt_nx = '0;
                idle_cnt_nx  = '0;
                if (s0_valid || s1_valid) begin
                    sel_nx   = pick;
                    state_nx = ST_LOCK;
`ifdef UART_ARB_TAG_EN
                    if (!last_vld || (last_src != pick))
                        state_nx = ST_TAG;
                    last_vld_nx = 1'b1;
                    last_src_nx = pick;
`endif
                end
            end

            ST_LOCK: begin
                m_data   = g_data;
                m_valid  = g_valid;
                s0_ready = (sel == SRC0) && m_ready;
                s1_ready = (sel == SRC1) && m_ready;
                xfer     = g_valid && m_ready;

                if (xfer)
                    burst_cnt_nx = burst_cnt + 7'd1;

                // Backpressured bytes still count as activity
                if (g_valid)
                    idle_cnt_nx = '0;
                else if (idle_cnt != 13'h1FFF)
                    idle_cnt_nx = idle_cnt + 13'd1;

                rel = (xfer && ((g_data == LF) || (burst_cnt + 7'd1 == BURST_LIM)))
                   || (!g_valid && (idle_cnt + 13'd1 == IDLE_LIM));

                if (rel) begin
                    state_nx  = ST_IDLE;
                    rr_ptr_nx = ~sel;
                end
            end

`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                m_valid      = 1'b1;
                m_data       = (sel == SRC1) ? TAG1 : TAG0;
                burst_cnt_nx = '0;
                idle_cnt_nx  = '0;
                if (m_ready)
                    state_nx = ST_LOCK;
            end
`endif

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Scoreboard bench for uart_tx_arbiter (honours UART_ARB_TAG_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic       src;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s0_data, s1_data, m_data;
    logic       s0_valid, s1_valid, s0_ready, s1_ready;
    logic       m_valid, m_ready, busy;
    logic [1:0] grant;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    exp_t       sb[$];

    int  vectors     = 0;
    int  miscompares = 0;
    bit  tb_last_vld = 1'b0;
    bit  tb_last     = 1'b0;
    int  bc, e0, e1, e2;

    uart_tx_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .s0_data  (s0_data),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s1_data  (s1_data),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .grant    (grant),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // A change of owner costs one tag byte when tagging is compiled in
    task automatic tag_for(input bit src, output int extra);
        extra = 0;
`ifdef UART_ARB_TAG_EN
        if (!tb_last_vld || (tb_last != src)) begin
            sb.push_back('{src: src, data: (src ? 8'h55 : 8'h43)});
            extra = 1;
        end
`endif
        tb_last_vld = 1'b1;
        tb_last     = src;
    endtask

    task automatic push(input bit src, input logic [7:0] d);
        if (src) q1.push_back(d);
        else     q0.push_back(d);
        sb.push_back('{src: src, data: d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input string tag, output int cycles);
        bit seen, done;
        int n;
        cycles = 0; seen = 1'b0; done = 1'b0; n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
            if (busy) begin
                seen = 1'b1;
                cycles++;
            end else if (seen) begin
                done = 1'b1;
            end
        end
        if (!done) chk({tag, "_bound"}, 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"},    grant,    0);
        chk({tag, "_busy"},     busy,     0);
        chk({tag, "_m_valid"},  m_valid,  0);
        chk({tag, "_s0_ready"}, s0_ready, 0);
        chk({tag, "_s1_ready"}, s1_ready, 0);
        chk({tag, "_m_data"},   m_data,   0);
    endtask

    // Source models plus output monitor: sample at negedge, update after posedge
    initial begin : src_drv
        bit   h0, h1;
        exp_t e;
        s0_valid = 1'b0; s1_valid = 1'b0;
        s0_data  = 8'h00; s1_data = 8'h00;
        forever begin
            @(negedge clk);
            h0 = s0_valid && s0_ready;
            h1 = s1_valid && s1_ready;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("m_data", m_data, e.data);
                    chk("grant_at_xfer", grant, e.src ? 2'b10 : 2'b01);
                end
            end
            if (s0_ready) chk("s0_ready_owner", grant, 2'b01);
            if (s1_ready) chk("s1_ready_owner", grant, 2'b10);
            @(posedge clk);
            #1;
            if (h0 && q0.size() > 0) void'(q0.pop_front());
            if (h1 && q1.size() > 0) void'(q1.pop_front());
            s0_valid = (q0.size() > 0);
            s0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
            s1_valid = (q1.size() > 0);
            s1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
        end
    end

    initial begin : main
        bit got;
        reset   = 1'b1;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        step();
        reset   = 1'b0;
        m_ready = 1'b1;

        // Source 0 line "AB\n": decision cycle then three back-to-back transfers
        tag_for(1'b0, e0);
        push(1'b0, 8'h41); push(1'b0, 8'h42); push(1'b0, 8'h0A);
        run_until_idle("t1", bc);
        chk("t1_busy_cycles", bc, 3 + e0);

        // rr_ptr now favours source 1; 70 bytes without LF hit the burst limit
        step();
        tag_for(1'b1, e1);
        for (int i = 0; i < 70; i++) q1.push_back(8'h20 + 8'(i));
        for (int i = 0; i < 64; i++) sb.push_back('{src: 1'b1, data: 8'h20 + 8'(i)});
        tag_for(1'b0, e0);
        push(1'b0, 8'h5A); push(1'b0, 8'h0A);
        tag_for(1'b1, e2);
        for (int i = 64; i < 70; i++) sb.push_back('{src: 1'b1, data: 8'h20 + 8'(i)});
        run_until_idle("t3a", bc);
        chk("t3_burst_cycles", bc, 64 + e1);
        run_until_idle("t3b", bc);
        chk("t3_waiter_cycles", bc, 2 + e0);
        run_until_idle("t3c", bc);
        chk("t3_tail_timeout_cycles", bc, 6 + 4800 + e2);

        // Two bytes then silence: released on the 4800th idle cycle
        step();
        tag_for(1'b0, e0);
        push(1'b0, 8'h61); push(1'b0, 8'h62);
        run_until_idle("t4", bc);
        chk("t4_timeout_cycles", bc, 2 + 4800 + e0);

        // Backpressure must never count as idle
        step();
        m_ready = 1'b0;
        tag_for(1'b0, e0);
        push(1'b0, 8'h51); push(1'b0, 8'h0A);
        repeat (10000) @(negedge clk);
        chk("t5_busy",    busy,    1);
        chk("t5_grant",   grant,   2'b01);
        chk("t5_m_valid", m_valid, 1);
        chk("t5_m_data",  m_data,  (e0 != 0) ? 8'h43 : 8'h51);
        chk("t5_q0_kept", q0.size(), 2);
        step();
        m_ready = 1'b1;
        run_until_idle("t5", bc);
        chk("t5_drain_cycles", bc, 2 + e0);

        // Simultaneous requests straight after reset: source 0 first
        step();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        tb_last_vld = 1'b0;
        tag_for(1'b0, e0);
        push(1'b0, 8'h41); push(1'b0, 8'h0A);
        tag_for(1'b1, e1);
        push(1'b1, 8'h62); push(1'b1, 8'h0A);
        run_until_idle("t2a", bc);
        chk("t2_src0_cycles", bc, 2 + e0);
        run_until_idle("t2b", bc);
        chk("t2_src1_cycles", bc, 2 + e1);

        // Reset while a byte is offered but not accepted
        step();
        m_ready = 1'b0;
        q0.push_back(8'h52); q0.push_back(8'h0A);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (m_valid) got = 1'b1;
        end
        chk("t6_m_valid_before", m_valid, 1);
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("t6");
        chk("t6_q0_kept", q0.size(), 2);
        step(); step();
        reset = 1'b0;
        tb_last_vld = 1'b0;
        tag_for(1'b0, e0);
        sb.push_back('{src: 1'b0, data: 8'h52});
        sb.push_back('{src: 1'b0, data: 8'h0A});
        m_ready = 1'b1;
        run_until_idle("t6", bc);
        chk("t6_retry_cycles", bc, 2 + e0);

        // Source 1 "x\n" twice; only a change of owner is tagged
        step();
        tag_for(1'b1, e1);
        push(1'b1, 8'h78); push(1'b1, 8'h0A);
        run_until_idle("t7a", bc);
        chk("t7_first_cycles", bc, 2 + e1);
        step();
        tag_for(1'b1, e1);
        push(1'b1, 8'h78); push(1'b1, 8'h0A);
        run_until_idle("t7b", bc);
        chk("t7_repeat_cycles", bc, 2 + e1);

        step();
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two byte-stream requesters, e.g. the CPU console and the USB host debug/HID-report dump.
- Grants the TX byte interface to one source at a time and keeps that grant for a whole line, so the two text streams never interleave mid-line.
- Sits between the requesters and the UART TX core inside the I/O subsystem. Runs on the 48 MHz system clock.

Parameters:
- IDLE_TIMEOUT, 4800, consecutive cycles with the granted source's valid low before the grant is released (100 us at 48 MHz).
- MAX_BURST, 64, maximum bytes per grant before a forced release.
- TAG0, 8'h43 ("C"), tag byte for source 0 (used only with the optional feature).
- TAG1, 8'h55 ("U"), tag byte for source 1 (used only with the optional feature).

Ports:
- clk  in  1  system clock, 48 MHz.
- reset  in  1  asynchronous, active-high reset.
- s0_data  in  8  source 0 byte.
- s0_valid  in  1  source 0 byte available.
- s0_ready  out  1  source 0 byte accepted.
- s1_data  in  8  source 1 byte.
- s1_valid  in  1  source 1 byte available.
- s1_ready  out  1  source 1 byte accepted.
- m_data  out  8  byte to the UART TX core.
- m_valid  out  1  byte valid toward the UART TX core.
- m_ready  in  1  UART TX core accepts the byte.
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface and handshake
  - One clock, clk. Reset is asynchronous and active-high.
  - A transfer occurs on a cycle where valid && ready are both high.
  - Reset values: grant=00, busy=0, m_valid=0, s0_ready=0, s1_ready=0, m_data=00.
  - Internal reset values: rr_ptr=0, burst_cnt=0, idle_cnt=0.
- States: IDLE, LOCK, plus TAG when the optional feature is compiled in.
- IDLE
  - m_valid=0 and both readys are 0.
  - If exactly one source has valid high, grant that source.
  - If both are high, grant the source selected by rr_ptr.
  - Next state is LOCK (or TAG, see Optional Feature).
  - No byte passes in the decision cycle. The first data transfer can occur at the earliest on the next cycle.
- LOCK (combinational pass-through from the registered grant)
  - m_data and m_valid are taken from the granted source.
  - The granted source's ready equals m_ready. The other source's ready is held at 0.
- burst_cnt
  - 7 bits wide; increments on each transfer; cleared when entering LOCK.
- idle_cnt
  - 13 bits wide; saturating.
  - Increments on each cycle the granted source's valid is low.
  - Clears on any cycle that valid is high.
  - Backpressure (valid high, m_ready low) never advances idle_cnt.
- Release conditions, evaluated on the transfer cycle itself or on the idle cycle:
  - the transferred byte is 8'h0A, or
  - burst_cnt+1 == MAX_BURST on a transfer, or
  - idle_cnt+1 == IDLE_TIMEOUT.
- On release:
  - Next state is IDLE, grant becomes 00, and rr_ptr is set to the other source.
  - The releasing byte still completes its transfer.
  - A pending request from the other source is granted on the IDLE cycle that follows.
- Line-feed coinciding with MAX_BURST is a single release, not two.
- The non-granted source keeps valid asserted without loss. No timeout applies to a waiting source.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs at their reset values.
  - A byte that was presented without a handshake is not consumed. Its source must retry.
- Throughput: 1 byte per cycle in LOCK when m_ready is held high.

Optional Feature:
- Macro name: UART_ARB_TAG_EN.
- With the macro defined:
  - From IDLE, if the new grant differs from the last granted source, enter TAG.
  - Last granted source resets to "none", so the first grant after reset is always tagged.
  - In TAG: m_valid=1, m_data=TAG0 or TAG1, both source readys are 0.
  - Advance to LOCK on m_ready.
  - The tag byte is not counted in burst_cnt, and idle_cnt is held at 0 while in TAG.
  - If the same source is re-granted, go straight to LOCK.
- Without the macro: no TAG state, no last-source register, and IDLE always goes to LOCK.

Decomposition:
- Package uart_arb_pkg holds:
  - the state encoding constants (ST_IDLE, ST_LOCK, ST_TAG);
  - the line-feed constant LF = 8'h0A;
  - the source index constants SRC0 and SRC1.
- No sub-module is needed. The round-robin pick and the counters are small enough to stay inline.

Test Plan:
- Source 0 sends "AB\n" with m_ready=1:
  - IDLE decision cycle, then 3 consecutive transfers;
  - grant=01 throughout;
  - release after 8'h0A, busy falls the cycle after.
- Both sources assert valid on the same cycle after reset:
  - source 0 is granted first;
  - after its LF, source 1 is granted on the next IDLE cycle;
  - s1_ready stays 0 until then.
- Source 1 streams 70 bytes with no LF:
  - release after exactly 64 transfers;
  - with source 0 waiting, source 0 is granted next.
- Source 0 sends 2 bytes, then drops valid for 4800 cycles:
  - release on cycle 4800 of idle.
- Timeout is not triggered by backpressure: hold m_ready=0 for 10000 cycles with s0_valid=1:
  - no release, and no byte is lost.
- Assert reset while m_valid=1 and m_ready=0:
  - outputs go to reset values asynchronously;
  - source byte is not acknowledged.
- With UART_ARB_TAG_EN, source 1 sends "x\n":
  - m_data sequence is 8'h55, 'x', 8'h0A.
  - A repeat by source 1 carries no tag.
